// File: rtl/grid_cursor_ctrl_pkg.sv
// Shared types and helpers for the battleship cursor/placement controller.
//   cursor_state_t : controller FSM states (IDLE, REQ, DONE)
//   coord_step     : one cursor step along an axis, saturating or wrapping
package battleship_pkg;

  localparam int unsigned DEF_ROWS      = 5;
  localparam int unsigned DEF_COLS      = 5;
  localparam int unsigned DEF_MAX_SHIPS = 8;
  localparam int unsigned DEF_ROW_W     = $clog2(DEF_ROWS);
  localparam int unsigned DEF_COL_W     = $clog2(DEF_COLS);
  localparam int unsigned DEF_SHIP_W    = $clog2(DEF_MAX_SHIPS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } cursor_state_t;

  // dec=1 steps towards 0, dec=0 steps towards max_idx.
  function automatic int unsigned coord_step(input int unsigned cur,
                                             input int unsigned max_idx,
                                             input logic        dec,
                                             input logic        wrap_en);
    if (dec) begin
      if (cur == 32'd0) return wrap_en ? max_idx : 32'd0;
      return cur - 32'd1;
    end
    if (cur >= max_idx) return wrap_en ? 32'd0 : max_idx;
    return cur + 32'd1;
  endfunction

endpackage

// File: rtl/grid_cursor_ctrl_if.sv
// Placement request channel between the cursor controller and board memory.
//   place_valid : request pending (master -> slave)
//   place_row   : requested row, stable while place_valid
//   place_col   : requested column, stable while place_valid
//   place_ready : board memory accepts the request (slave -> master)
interface grid_cursor_ctrl_if #(
  parameter int unsigned ROW_W = 3,
  parameter int unsigned COL_W = 3
);
  logic             place_valid;
  logic             place_ready;
  logic [ROW_W-1:0] place_row;
  logic [COL_W-1:0] place_col;

  modport master (output place_valid, place_row, place_col, input place_ready);
  modport slave  (input place_valid, place_row, place_col, output place_ready);
endinterface

// File: rtl/grid_cursor_ctrl_btn_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, press-edge detect, optional
// auto-repeat while held. step_o is a registered one-cycle pulse.
//   clk, rst : clock, synchronous active-high reset
//   btn_n_i  : asynchronous active-low button
//   step_o   : step pulse (press, then repeats while held if enabled)
module btn_conditioner #(
  parameter bit          REPEAT_EN     = 1'b1,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 6250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic step_o
);
  localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);
  localparam bit RPT = REPEAT_EN && (REPEAT_DELAY > 0);

  logic             sync1_q, sync2_q, held_q, step_q, rpt_q;
  logic             rpt_d, step_d, held, press;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign held  = ~sync2_q;
  assign press = held & ~held_q;

  // cnt_q counts cycles since the last pulse; the first repeat waits
  // REPEAT_DELAY, later ones REPEAT_PERIOD. Release clears everything.
  always_comb begin
    cnt_d  = '0;
    rpt_d  = 1'b0;
    step_d = press;
    if (RPT && held && !press) begin
      rpt_d = rpt_q;
      if (cnt_q == (rpt_q ? PER_LAST : DLY_LAST)) begin
        step_d = 1'b1;
        rpt_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      held_q  <= 1'b0;
      step_q  <= 1'b0;
      rpt_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
      held_q  <= held;
      step_q  <= step_d;
      rpt_q   <= rpt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign step_o = step_q;
endmodule

// File: rtl/grid_cursor_ctrl.sv
// Board cursor and ship-placement controller.
//   clk, rst      : clock, synchronous active-high reset
//   btn_*_n       : active-low up/down/left/right/select buttons (async)
//   ships_total   : number of ships to place (sampled in IDLE)
//   place_if      : placement request channel (valid/ready, row/col payload)
//   row, col      : cursor position for the renderer
//   ships_placed  : accepted placements
//   done          : all ships placed
module grid_cursor_ctrl
  import battleship_pkg::*;
#(
  parameter int unsigned ROWS          = DEF_ROWS,
  parameter int unsigned COLS          = DEF_COLS,
  parameter bit          WRAP          = 1'b0,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 6250000,
  parameter int unsigned MAX_SHIPS     = DEF_MAX_SHIPS,
  localparam int unsigned ROW_W  = $clog2(ROWS),
  localparam int unsigned COL_W  = $clog2(COLS),
  localparam int unsigned SHIP_W = $clog2(MAX_SHIPS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_up_n,
  input  logic                btn_down_n,
  input  logic                btn_left_n,
  input  logic                btn_right_n,
  input  logic                btn_sel_n,
  input  logic [SHIP_W-1:0]   ships_total,
  grid_cursor_ctrl_if.master  place_if,
  output logic [ROW_W-1:0]    row,
  output logic [COL_W-1:0]    col,
  output logic [SHIP_W-1:0]   ships_placed,
  output logic                done
);
  logic step_up, step_down, step_left, step_right, step_sel;

  btn_conditioner #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_up    (.clk(clk), .rst(rst), .btn_n_i(btn_up_n),    .step_o(step_up));
  btn_conditioner #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_down  (.clk(clk), .rst(rst), .btn_n_i(btn_down_n),  .step_o(step_down));
  btn_conditioner #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_left  (.clk(clk), .rst(rst), .btn_n_i(btn_left_n),  .step_o(step_left));
  btn_conditioner #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_right (.clk(clk), .rst(rst), .btn_n_i(btn_right_n), .step_o(step_right));
  btn_conditioner #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_sel   (.clk(clk), .rst(rst), .btn_n_i(btn_sel_n),   .step_o(step_sel));

  cursor_state_t     state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d, prow_q, prow_d;
  logic [COL_W-1:0]  col_q, col_d, pcol_q, pcol_d;
  logic [SHIP_W-1:0] ships_q, ships_d;
  logic              valid_q, valid_d, done_q, done_d;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    prow_d  = prow_q;
    pcol_d  = pcol_q;
    ships_d = ships_q;
    valid_d = valid_q;
    done_d  = done_q;

    // Opposing directions in the same cycle cancel on that axis.
    if (state_q != REQ) begin
      if (step_up ^ step_down)
        row_d = ROW_W'(coord_step(32'(row_q), ROWS - 1, step_up, WRAP));
      if (step_left ^ step_right)
        col_d = COL_W'(coord_step(32'(col_q), COLS - 1, step_left, WRAP));
    end

    unique case (state_q)
      IDLE: begin
        // Completion wins over select so ships_placed cannot pass ships_total.
        if (ships_q >= ships_total) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (step_sel) begin
          prow_d  = row_q;
          pcol_d  = col_q;
          valid_d = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (place_if.place_ready) begin
          valid_d = 1'b0;
          ships_d = ships_q + 1'b1;
          state_d = IDLE;
        end
      end
      DONE:    ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      prow_q  <= '0;
      pcol_q  <= '0;
      ships_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      prow_q  <= prow_d;
      pcol_q  <= pcol_d;
      ships_q <= ships_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign row                  = row_q;
  assign col                  = col_q;
  assign ships_placed         = ships_q;
  assign done                 = done_q;
  assign place_if.place_valid = valid_q;
  assign place_if.place_row   = prow_q;
  assign place_if.place_col   = pcol_q;
endmodule
